// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
//   master : pipeline control side (drives ID/EX fields, sees EX/MEM + stall)
//   slave  : ex_stage itself
// Signal names match the legacy flat port list of ex_stage.
interface ex_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_ex;
  logic             regwrite_ex;
  logic             memtoreg_ex;
  logic             memwrite_ex;
  logic [3:0]       alucontrol_ex;
  logic             alusrc_ex;
  logic             regdst_ex;
  logic [WIDTH-1:0] rd1_ex;
  logic [WIDTH-1:0] rd2_ex;
  logic [WIDTH-1:0] signimm_ex;
  logic [4:0]       rte_ex;
  logic [4:0]       rde_ex;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic [WIDTH-1:0] result_wb;
  logic             flush_e;
  logic [WIDTH-1:0] aluout_mem;
  logic [WIDTH-1:0] writedata_mem;
  logic [4:0]       writereg_mem;
  logic             regwrite_mem;
  logic             memtoreg_mem;
  logic             memwrite_mem;
  logic             valid_mem;
  logic             mul_busy;

  modport master (
    output valid_ex, regwrite_ex, memtoreg_ex, memwrite_ex, alucontrol_ex,
           alusrc_ex, regdst_ex, rd1_ex, rd2_ex, signimm_ex, rte_ex, rde_ex,
           forward_a, forward_b, result_wb, flush_e,
    input  aluout_mem, writedata_mem, writereg_mem, regwrite_mem,
           memtoreg_mem, memwrite_mem, valid_mem, mul_busy
  );

  modport slave (
    input  valid_ex, regwrite_ex, memtoreg_ex, memwrite_ex, alucontrol_ex,
           alusrc_ex, regdst_ex, rd1_ex, rd2_ex, signimm_ex, rte_ex, rde_ex,
           forward_a, forward_b, result_wb, flush_e,
    output aluout_mem, writedata_mem, writereg_mem, regwrite_mem,
           memtoreg_mem, memwrite_mem, valid_mem, mul_busy
  );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage. Forwarding muxes, ALU, EX/MEM pipeline
// register and an iterative shift-add multiplier (one bit per cycle) that
// raises mul_busy to stall upstream while it runs.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   ex      : ex_stage_if.slave (ID/EX fields in, EX/MEM fields + mul_busy out)
module ex_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input logic       clk,
  input logic       reset_n,
  ex_stage_if.slave ex
);
  localparam int unsigned   CW     = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] LAST   = CW'(MUL_CYCLES - 1);
  localparam logic [3:0]    OP_AND = 4'b0000;
  localparam logic [3:0]    OP_OR  = 4'b0001;
  localparam logic [3:0]    OP_ADD = 4'b0010;
  localparam logic [3:0]    OP_SUB = 4'b0110;
  localparam logic [3:0]    OP_SLT = 4'b0111;
  localparam logic [3:0]    OP_MUL = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] mwdata_q, mwdata_d;
  logic [4:0]       mwreg_q, mwreg_d;
  logic             mregwrite_q, mregwrite_d;
  logic             mmemtoreg_q, mmemtoreg_d;
  logic             mmemwrite_q, mmemwrite_d;

  logic [WIDTH-1:0] aluout_q, aluout_d;
  logic [WIDTH-1:0] writedata_q, writedata_d;
  logic [4:0]       writereg_q, writereg_d;
  logic             regwrite_q, regwrite_d;
  logic             memtoreg_q, memtoreg_d;
  logic             memwrite_q, memwrite_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_y;
  logic [4:0]       dest;
  logic             mul_start;

  always_comb begin
    case (ex.forward_a)
      2'b01:   src_a = ex.result_wb;
      2'b10:   src_a = aluout_q;
      default: src_a = ex.rd1_ex;
    endcase
    case (ex.forward_b)
      2'b01:   fwd_b = ex.result_wb;
      2'b10:   fwd_b = aluout_q;
      default: fwd_b = ex.rd2_ex;
    endcase
    src_b = ex.alusrc_ex ? ex.signimm_ex : fwd_b;
    dest  = ex.regdst_ex ? ex.rde_ex : ex.rte_ex;
  end

  always_comb begin
    case (ex.alucontrol_ex)
      OP_AND:  alu_y = src_a & src_b;
      OP_OR:   alu_y = src_a | src_b;
      OP_ADD:  alu_y = src_a + src_b;
      OP_SUB:  alu_y = src_a - src_b;
      OP_SLT:  alu_y = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_y = '0;
    endcase
  end

  assign mul_start = (state_q == IDLE) && ex.valid_ex && !ex.flush_e &&
                     (ex.alucontrol_ex == OP_MUL);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    mwdata_d    = mwdata_q;
    mwreg_d     = mwreg_q;
    mregwrite_d = mregwrite_q;
    mmemtoreg_d = mmemtoreg_q;
    mmemwrite_d = mmemwrite_q;
    // EX/MEM loads a bubble unless a branch below says otherwise.
    aluout_d    = '0;
    writedata_d = '0;
    writereg_d  = '0;
    regwrite_d  = 1'b0;
    memtoreg_d  = 1'b0;
    memwrite_d  = 1'b0;
    valid_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (mul_start) begin
          // Operands are frozen here so MEM/WB draining during the multiply
          // cannot change the forwarded values.
          mcand_d     = src_a;
          mplier_d    = src_b;
          mwdata_d    = fwd_b;
          mwreg_d     = dest;
          mregwrite_d = ex.regwrite_ex;
          mmemtoreg_d = ex.memtoreg_ex;
          mmemwrite_d = ex.memwrite_ex;
          acc_d       = '0;
          count_d     = '0;
          state_d     = MUL;
        end else if (ex.valid_ex && !ex.flush_e) begin
          aluout_d    = alu_y;
          writedata_d = fwd_b;
          writereg_d  = dest;
          regwrite_d  = ex.regwrite_ex;
          memtoreg_d  = ex.memtoreg_ex;
          memwrite_d  = ex.memwrite_ex;
          valid_d     = 1'b1;
        end
      end
      MUL: begin
        if (ex.flush_e) begin
          state_d = IDLE;
        end else begin
          if (mplier_q[count_q]) begin
            acc_d = acc_q + (mcand_q << count_q);
          end
          count_d = count_q + 1'b1;
          if (count_q == LAST) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!ex.flush_e) begin
          aluout_d    = acc_q;
          writedata_d = mwdata_q;
          writereg_d  = mwreg_q;
          regwrite_d  = mregwrite_q;
          memtoreg_d  = mmemtoreg_q;
          memwrite_d  = mmemwrite_q;
          valid_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      mwdata_q    <= '0;
      mwreg_q     <= '0;
      mregwrite_q <= 1'b0;
      mmemtoreg_q <= 1'b0;
      mmemwrite_q <= 1'b0;
      aluout_q    <= '0;
      writedata_q <= '0;
      writereg_q  <= '0;
      regwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      mwdata_q    <= mwdata_d;
      mwreg_q     <= mwreg_d;
      mregwrite_q <= mregwrite_d;
      mmemtoreg_q <= mmemtoreg_d;
      mmemwrite_q <= mmemwrite_d;
      aluout_q    <= aluout_d;
      writedata_q <= writedata_d;
      writereg_q  <= writereg_d;
      regwrite_q  <= regwrite_d;
      memtoreg_q  <= memtoreg_d;
      memwrite_q  <= memwrite_d;
      valid_q     <= valid_d;
    end
  end

  assign ex.aluout_mem    = aluout_q;
  assign ex.writedata_mem = writedata_q;
  assign ex.writereg_mem  = writereg_q;
  assign ex.regwrite_mem  = regwrite_q;
  assign ex.memtoreg_mem  = memtoreg_q;
  assign ex.memwrite_mem  = memwrite_q;
  assign ex.valid_mem     = valid_q;
  assign ex.mul_busy      = mul_start || (state_q == MUL);
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  logic clk;
  logic reset_n;
  int unsigned n_cmp;
  int unsigned n_err;

  ex_stage_if #(.WIDTH(32)) bus ();

  ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ex      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        valid, flush;
    logic [3:0]  op;
    logic        alusrc, regdst, regwrite, memtoreg, memwrite;
    logic [1:0]  fa, fb;
    logic [31:0] rd1, rd2, imm, wb;
    logic [4:0]  rte, rde;
    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_wr;
    logic        e_v, e_rw, e_mtr, e_mw;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.valid_ex      = 1'b0;
    bus.regwrite_ex   = 1'b0;
    bus.memtoreg_ex   = 1'b0;
    bus.memwrite_ex   = 1'b0;
    bus.alucontrol_ex = 4'h0;
    bus.alusrc_ex     = 1'b0;
    bus.regdst_ex     = 1'b0;
    bus.rd1_ex        = '0;
    bus.rd2_ex        = '0;
    bus.signimm_ex    = '0;
    bus.rte_ex        = '0;
    bus.rde_ex        = '0;
    bus.forward_a     = 2'b00;
    bus.forward_b     = 2'b00;
    bus.result_wb     = '0;
    bus.flush_e       = 1'b0;
  endtask

  task automatic drive_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    drive_idle();
    bus.valid_ex      = 1'b1;
    bus.alucontrol_ex = 4'b1000;
    bus.rd1_ex        = a;
    bus.rd2_ex        = b;
    bus.regdst_ex     = 1'b1;
    bus.rde_ex        = rd;
    bus.rte_ex        = 5'd30;
    bus.regwrite_ex   = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " aluout"},   bus.aluout_mem,    32'h0);
    chk({tag, " wdata"},    bus.writedata_mem, 32'h0);
    chk({tag, " wreg"},     {27'h0, bus.writereg_mem}, 32'h0);
    chk({tag, " ctrl"},     {28'h0, bus.valid_mem, bus.regwrite_mem,
                             bus.memtoreg_mem, bus.memwrite_mem}, 32'h0);
    chk({tag, " busy"},     {31'h0, bus.mul_busy}, 32'h0);
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit disturb, input string tag);
    int unsigned busy_cnt;
    int unsigned vpulse;
    busy_cnt = 0;
    vpulse   = 0;
    drive_mul(a, b, rd);
    #1;
    if (bus.mul_busy) busy_cnt++;
    for (int c = 1; c <= 33; c++) begin
      @(posedge clk); #1;
      if (bus.valid_mem) vpulse++;
      if (disturb) begin
        bus.forward_a = 2'($urandom_range(0, 3));
        bus.forward_b = 2'($urandom_range(0, 3));
        bus.rd1_ex    = $urandom;
        bus.rd2_ex    = $urandom;
        bus.result_wb = $urandom;
        #1;
      end
      if (bus.mul_busy) busy_cnt++;
    end
    @(posedge clk); #1;
    chk({tag, " busy cycles"}, busy_cnt, 32'd33);
    chk({tag, " early valid"}, vpulse, 32'd0);
    chk({tag, " aluout"}, bus.aluout_mem, exp);
    chk({tag, " wreg"}, {27'h0, bus.writereg_mem}, {27'h0, rd});
    chk({tag, " valid"}, {31'h0, bus.valid_mem}, 32'd1);
    chk({tag, " regwrite"}, {31'h0, bus.regwrite_mem}, 32'd1);
    chk({tag, " memtoreg"}, {31'h0, bus.memtoreg_mem}, 32'd0);
    drive_idle();
    #1;
    chk({tag, " busy after"}, {31'h0, bus.mul_busy}, 32'd0);
  endtask

  task automatic do_add(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input string tag);
    drive_idle();
    bus.valid_ex      = 1'b1;
    bus.alucontrol_ex = 4'b0010;
    bus.rd1_ex        = a;
    bus.rd2_ex        = b;
    bus.regdst_ex     = 1'b1;
    bus.rde_ex        = rd;
    bus.regwrite_ex   = 1'b1;
    @(posedge clk); #1;
    chk({tag, " aluout"}, bus.aluout_mem, a + b);
    chk({tag, " valid"}, {31'h0, bus.valid_mem}, 32'd1);
    chk({tag, " wreg"}, {27'h0, bus.writereg_mem}, {27'h0, rd});
    drive_idle();
  endtask

  initial begin
    int unsigned vpulse;
    n_cmp = 0;
    n_err = 0;
    // field order: valid flush op alusrc regdst regwrite memtoreg memwrite fa fb
    //              rd1 rd2 imm wb rte rde | alu wd wr v rw mtr mw
    // Rows run back to back; forward 10 picks up the previous row's result.
    vecs[0]  = '{1, 0, 4'h2, 0, 1, 1, 0, 0, 2'b00, 2'b00, 32'd100, 32'd0, 32'd0, 32'd0,
                 5'd4, 5'd3, 32'd100, 32'd0, 5'd3, 1, 1, 0, 0};
    vecs[1]  = '{1, 0, 4'h2, 0, 0, 1, 0, 0, 2'b10, 2'b00, 32'd5, 32'd3, 32'd0, 32'd0,
                 5'd7, 5'd1, 32'd103, 32'd3, 5'd7, 1, 1, 0, 0};
    vecs[2]  = '{1, 0, 4'h6, 1, 0, 0, 0, 1, 2'b00, 2'b01, 32'd0, 32'h55, 32'hFFFFFFFF,
                 32'h10, 5'd2, 5'd1, 32'h1, 32'h10, 5'd2, 1, 0, 0, 1};
    vecs[3]  = '{1, 0, 4'h7, 0, 1, 1, 0, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'd1, 32'd0,
                 32'd0, 5'd1, 5'd5, 32'd1, 32'd1, 5'd5, 1, 1, 0, 0};
    vecs[4]  = '{1, 0, 4'h7, 0, 1, 1, 0, 0, 2'b00, 2'b00, 32'd1, 32'hFFFFFFFF, 32'd0,
                 32'd0, 5'd1, 5'd6, 32'd0, 32'hFFFFFFFF, 5'd6, 1, 1, 0, 0};
    vecs[5]  = '{1, 0, 4'h0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 32'hF0F0FF00, 32'h0FF0F0F0,
                 32'd0, 32'd0, 5'd0, 5'd8, 32'h00F0F000, 32'h0FF0F0F0, 5'd8, 1, 1, 0, 0};
    vecs[6]  = '{1, 0, 4'h1, 0, 1, 1, 0, 0, 2'b00, 2'b00, 32'hF0F0FF00, 32'h0FF0F0F0,
                 32'd0, 32'd0, 5'd0, 5'd9, 32'hFFF0FFF0, 32'h0FF0F0F0, 5'd9, 1, 1, 0, 0};
    vecs[7]  = '{1, 0, 4'h2, 0, 1, 1, 0, 0, 2'b11, 2'b11, 32'd1, 32'd2, 32'd0, 32'h1000,
                 5'd0, 5'd10, 32'd3, 32'd2, 5'd10, 1, 1, 0, 0};
    vecs[8]  = '{1, 0, 4'h3, 0, 1, 1, 0, 0, 2'b00, 2'b00, 32'd5, 32'd6, 32'd0, 32'd0,
                 5'd0, 5'd11, 32'd0, 32'd6, 5'd11, 1, 1, 0, 0};
    vecs[9]  = '{0, 0, 4'h2, 0, 1, 1, 0, 1, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0,
                 5'd0, 5'd12, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 4'h2, 0, 1, 1, 1, 0, 2'b00, 2'b00, 32'd1, 32'd1, 32'd0, 32'd0,
                 5'd0, 5'd12, 32'd0, 32'd0, 5'd0, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 4'h2, 0, 0, 1, 1, 0, 2'b01, 2'b00, 32'd9, 32'd2, 32'd0,
                 32'hFFFFFFFF, 5'd12, 5'd0, 32'd1, 32'd2, 5'd12, 1, 1, 1, 0};
    vecs[12] = '{1, 0, 4'h6, 0, 1, 1, 0, 0, 2'b00, 2'b10, 32'd0, 32'd7, 32'd0, 32'd0,
                 5'd0, 5'd13, 32'hFFFFFFFF, 32'd1, 5'd13, 1, 1, 0, 0};

    reset_n = 1'b0;
    drive_idle();
    @(posedge clk); @(posedge clk); #1;
    chk_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.valid_ex      = vecs[i].valid;
      bus.flush_e       = vecs[i].flush;
      bus.alucontrol_ex = vecs[i].op;
      bus.alusrc_ex     = vecs[i].alusrc;
      bus.regdst_ex     = vecs[i].regdst;
      bus.regwrite_ex   = vecs[i].regwrite;
      bus.memtoreg_ex   = vecs[i].memtoreg;
      bus.memwrite_ex   = vecs[i].memwrite;
      bus.forward_a     = vecs[i].fa;
      bus.forward_b     = vecs[i].fb;
      bus.rd1_ex        = vecs[i].rd1;
      bus.rd2_ex        = vecs[i].rd2;
      bus.signimm_ex    = vecs[i].imm;
      bus.result_wb     = vecs[i].wb;
      bus.rte_ex        = vecs[i].rte;
      bus.rde_ex        = vecs[i].rde;
      @(posedge clk); #1;
      chk($sformatf("row%0d aluout", i), bus.aluout_mem, vecs[i].e_alu);
      chk($sformatf("row%0d wdata", i), bus.writedata_mem, vecs[i].e_wd);
      chk($sformatf("row%0d wreg", i), {27'h0, bus.writereg_mem}, {27'h0, vecs[i].e_wr});
      chk($sformatf("row%0d valid", i), {31'h0, bus.valid_mem}, {31'h0, vecs[i].e_v});
      chk($sformatf("row%0d regwrite", i), {31'h0, bus.regwrite_mem}, {31'h0, vecs[i].e_rw});
      chk($sformatf("row%0d memtoreg", i), {31'h0, bus.memtoreg_mem}, {31'h0, vecs[i].e_mtr});
      chk($sformatf("row%0d memwrite", i), {31'h0, bus.memwrite_mem}, {31'h0, vecs[i].e_mw});
      chk($sformatf("row%0d busy", i), {31'h0, bus.mul_busy}, 32'd0);
    end

    // Asynchronous reset away from any clock edge clears the last row's result at once.
    #1 reset_n = 1'b0;
    #1;
    chk_zero("async reset");
    reset_n = 1'b1;
    drive_idle();
    @(posedge clk); #1;

    do_mul(32'd7, 32'd6, 5'd9, 32'd42, 1'b0, "mul 7x6");
    do_mul(32'hFFFFFFFF, 32'd2, 5'd14, 32'hFFFFFFFE, 1'b1, "mul ffffffffx2 disturbed");
    do_mul(32'h12345678, 32'd0, 5'd15, 32'd0, 1'b0, "mul by zero");
    do_mul(32'h00010001, 32'h00010001, 5'd16, 32'h00020001, 1'b0, "mul 10001sq");

    // Flush in the tenth MUL cycle aborts with no result.
    vpulse = 0;
    drive_mul(32'd3, 32'd4, 5'd18);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (bus.valid_mem) vpulse++;
    end
    chk("flush busy in mul", {31'h0, bus.mul_busy}, 32'd1);
    bus.flush_e = 1'b1;
    @(posedge clk); #1;
    chk("flush busy next", {31'h0, bus.mul_busy}, 32'd0);
    drive_idle();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.valid_mem) vpulse++;
    end
    chk("flush no valid", vpulse, 32'd0);
    do_add(32'd11, 32'd22, 5'd19, "add after flush");

    // Reset in the twentieth MUL cycle.
    drive_mul(32'd9, 32'd9, 5'd20);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
    end
    chk("reset busy in mul", {31'h0, bus.mul_busy}, 32'd1);
    reset_n = 1'b0;
    drive_idle();
    #1;
    chk_zero("mid-mul reset");
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    do_add(32'd20, 32'd22, 5'd17, "add after reset");
    do_mul(32'd3, 32'd5, 5'd21, 32'd15, 1'b0, "mul after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
